mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Sequencer and two-port arbiter in front of the 8x8 sign-magnitude shift-and-add multiplier core. Accepts multiply jobs from two requesters, grants the single core round-robin, and loads operands and restarts the core through its load/clear input. It waits for the core's finish flag, then returns the 16-bit product with a one-cycle acknowledge. The arbiter sits between the core and the rest of the datapath; the core is never driven directly by requesters.

## Interface
- TIMEOUT_CYCLES, 31: RUN-state cycle limit before a job is aborted. Used only when the watchdog is compiled in. Range 9..255.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req0 / req1  in  1  job request; held high with stable operands until the matching ack
- w0 / w1  in  8  multiplicand, sign-magnitude: bit 7 sign, bits 6:0 magnitude
- y0 / y1  in  8  multiplier, same format
- ack0 / ack1  out  1  one-cycle pulse; result valid in the same cycle
- z0 / z1  out  16  product for that requester, held until the next ack to the same port
- err0 / err1  out  1  qualifies ack: job aborted by watchdog
- mul_load  out  1  one-cycle pulse to the core; clears the core and loads mul_w/mul_y
- mul_w, mul_y  out  8  operands to the core, stable from LOAD until the job leaves RUN
- mul_finish  in  1  core done flag
- mul_z  in  16  core product, valid while mul_finish=1
- busy  out  1  high in every state except IDLE
- grant_id  out  1  requester currently being served; valid while busy

## Operation
- States: IDLE, LOAD, RUN, RESP. Encoded in 2 bits.
- IDLE:
  - If neither request is active, stay in IDLE.
  - If only one request is active, grant it.
  - If both are active, grant the port that was not served last.
  - Priority pointer `last` resets to 1, so port 0 wins the first tie.
  - On grant: latch the granted operands into mul_w/mul_y, set grant_id, go to LOAD.
- LOAD: drive mul_load=1 for exactly one cycle, clear the watchdog counter, go to RUN.
- RUN:
  - When mul_finish=1, capture mul_z into the z register of the granted port and go to RESP.
  - mul_finish is ignored in every other state.
- RESP:
  - Pulse ack and err for the granted port.
  - Update last to grant_id, go to IDLE.
- Operands are latched at grant. Changes on w/y after grant do not affect the running job.
- A req dropped after grant is still served; its ack is issued regardless.
- The arbiter does not modify the product. The sign bit and magnitude pass through bit-exactly, including negative zero (0x8000).
- Only one job is in flight at a time. There is no queueing beyond the two request lines.

## Timing
- Reset values: ack0/1=0, err0/1=0, z0/z1=0x0000, mul_load=0, mul_w/mul_y=0x00, busy=0, grant_id=0, state=IDLE, last=1.
- Reset at any point, including mid-RUN:
  - Returns to IDLE on the next edge with no ack issued.
  - The interrupted job is lost; the requester must re-request.
- Request sampled in IDLE at edge t:
  - mul_load high in cycle t+1.
  - RUN entered at t+2.
  - ack in the cycle after the edge on which mul_finish is sampled high.
- Request-to-ack latency = 3 + L_core cycles, where L_core is cycles from mul_load to mul_finish.
- Back-to-back jobs:
  - IDLE is always visited for one cycle after RESP.
  - A requester may deassert req in the ack cycle. If req is still high in the following IDLE cycle, it is treated as a new request.
- Simultaneous req0 and req1 with the other request held: grants alternate 0,1,0,1 for as long as both stay high.

## Configuration
- MULT_ARB_TIMEOUT_EN defined:
  - An 8-bit counter runs in RUN.
  - When it reaches TIMEOUT_CYCLES without mul_finish, go to RESP with err=1 and z=0x0000 for the granted port.
  - The next job's mul_load restarts the core.
- MULT_ARB_TIMEOUT_EN undefined:
  - No counter is built; RUN waits indefinitely.
  - err0/err1 are tied to 0.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Reset, then req0 with w0=0x85, y0=0x03, core model returns 0x800F → exactly one mul_load pulse with mul_w=0x85, mul_y=0x03; ack0 pulse with z0=0x800F, err0=0; ack1 never pulses.
- req0 and req1 raised in the same cycle after reset (w0=0x02, y0=0x03; w1=0x84, y1=0x84) → port 0 served first with z0=0x0006, then port 1 with z1=0x0010; grant_id goes 0 then 1.
- Both requests held high for 4 jobs → grant order 0,1,0,1; exactly one IDLE cycle between each ack and the next mul_load.
- rst asserted for one cycle at RUN cycle 3 of a req1 job → no ack1; all outputs at reset values on the next cycle; re-request completes normally.
- w0 changed from 0x05 to 0x7F one cycle after grant → core still receives 0x05; z0 equals the product for 0x05.
- With MULT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=31, core holds mul_finish=0 → ack0 with err0=1 and z0=0x0000 at 31 RUN cycles; without the macro, busy stays high and no ack is issued.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: two-port round-robin sequencer in front of the 8x8
// sign-magnitude shift-and-add multiplier core. Grants one job at a time,
// loads the core, waits for its finish flag and returns the product with a
// one-cycle acknowledge to the requesting port.
// Optional RUN-state watchdog: define MULT_ARB_TIMEOUT_EN to build it.
module mult_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  w0,
  input  logic [7:0]  y0,
  input  logic [7:0]  w1,
  input  logic [7:0]  y1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] z0,
  output logic [15:0] z1,
  output logic        err0,
  output logic        err1,
  output logic        mul_load,
  output logic [7:0]  mul_w,
  output logic [7:0]  mul_y,
  input  logic        mul_finish,
  input  logic [15:0] mul_z,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 9 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mult_arbiter: TIMEOUT_CYCLES must be within 9..255");
  end

  state_t r_state;
  logic   r_last;
  logic   w_any;
  logic   w_pick;
  logic   w_tmo;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam logic [7:0] LP_WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wdog;
  logic       r_err0;
  logic       r_err1;

  assign w_tmo = (r_wdog == LP_WDOG_LAST);
  assign err0  = r_err0;
  assign err1  = r_err1;
`else
  assign w_tmo = 1'b0;
  assign err0  = 1'b0;
  assign err1  = 1'b0;
`endif

  // Round-robin pick: a lone request wins; on a tie the port not served last wins
  always_comb begin
    w_any  = req0 | req1;
    w_pick = 1'b0;
    if (req0 && req1) begin
      w_pick = ~r_last;
    end else begin
      w_pick = req1;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      z0       <= '0;
      z1       <= '0;
      mul_load <= 1'b0;
      mul_w    <= '0;
      mul_y    <= '0;
      busy     <= 1'b0;
      grant_id <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_wdog   <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
`endif
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      mul_load <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            grant_id <= w_pick;
            mul_w    <= w_pick ? w1 : w0;
            mul_y    <= w_pick ? y1 : y0;
            mul_load <= 1'b1;
            busy     <= 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
`ifdef MULT_ARB_TIMEOUT_EN
          r_wdog  <= '0;
`endif
          r_state <= RUN;
        end
        RUN: begin
          if (mul_finish) begin
            if (grant_id) begin
              z1   <= mul_z;
              ack1 <= 1'b1;
            end else begin
              z0   <= mul_z;
              ack0 <= 1'b1;
            end
            r_state <= RESP;
          end else if (w_tmo) begin
            // Watchdog abort: zero product, err qualifies the ack
            if (grant_id) begin
              z1   <= '0;
              ack1 <= 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
              r_err1 <= 1'b1;
`endif
            end else begin
              z0   <= '0;
              ack0 <= 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
              r_err0 <= 1'b1;
`endif
            end
            r_state <= RESP;
          end else begin
`ifdef MULT_ARB_TIMEOUT_EN
            r_wdog <= r_wdog + 8'd1;
`endif
          end
        end
        RESP: begin
          r_last  <= grant_id;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: a behavioural core model answers each
// mul_load, port drivers push expected products per port, and a negedge
// monitor pops and compares on every ack.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  w0 = '0, y0 = '0, w1 = '0, y1 = '0;
  logic        ack0, ack1, err0, err1, mul_load, busy, grant_id;
  logic [15:0] z0, z1;
  logic [7:0]  mul_w, mul_y;
  logic        mul_finish = 1'b0;
  logic [15:0] mul_z = '0;

  int checks = 0;
  int failures = 0;
  int load_count = 0;
  int fixed_lat = -1;
  bit stall = 1'b0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  mult_arbiter #(.TIMEOUT_CYCLES(31)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .w0(w0), .y0(y0), .w1(w1), .y1(y1),
    .ack0(ack0), .ack1(ack1),
    .z0(z0), .z1(z1),
    .err0(err0), .err1(err1),
    .mul_load(mul_load), .mul_w(mul_w), .mul_y(mul_y),
    .mul_finish(mul_finish), .mul_z(mul_z),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Sign-magnitude product from the number rules: sign XOR, magnitude multiply
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int unsigned m;
    m = int'(a & 8'h7F) * int'(b & 8'h7F);
    return {a[7] ^ b[7], 15'(m)};
  endfunction

  function automatic logic [7:0] rand_op();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 7))
      0: return {s, 7'h00};
      1: return {s, 7'h7F};
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic [7:0] a, input logic [7:0] b);
    if (p == 0) begin
      req0 = r; w0 = a; y0 = b;
    end else begin
      req1 = r; w1 = a; y1 = b;
    end
  endtask

  task automatic push_exp(input int p, input logic [16:0] e);
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_grant(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mul_load && grant_id == 1'(p)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL grant_timeout port %0d: got none expected grant within 300 cycles", p);
    end
  endtask

  task automatic wait_ack(input int p, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout port %0d: got none expected ack within 300 cycles", p);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // One directed job; mutate rewrites the multiplicand while the job is in LOAD
  task automatic one_job(input int p, input logic [7:0] a, input logic [7:0] b,
                         input logic [16:0] e, input bit mutate);
    bit ok;
    int cyc;
    set_port(p, 1'b1, a, b);
    push_exp(p, e);
    wait_grant(p, ok);
    if (mutate) begin
      #1 set_port(p, 1'b1, 8'h7F, b);
    end
    if (ok) wait_ack(p, cyc);
    @(posedge clk); #1;
    set_port(p, 1'b0, a, b);
  endtask

  // mode 0: random holds/drops/mutations; mode 1: request held continuously
  task automatic drive_jobs(input int p, input int n, input int mode);
    logic [7:0] a, b;
    bit ok;
    int cyc;
    for (int j = 0; j < n; j++) begin
      a = rand_op();
      b = rand_op();
      set_port(p, 1'b1, a, b);
      push_exp(p, {1'b0, ref_prod(a, b)});
      wait_grant(p, ok);
      if (ok && mode == 0 && $urandom_range(0, 1) == 1) begin
        #1 set_port(p, 1'($urandom), rand_op(), rand_op());
      end
      if (ok) wait_ack(p, cyc);
      @(posedge clk); #1;
      if (j == n - 1 || (mode == 0 && $urandom_range(0, 1) == 1)) begin
        set_port(p, 1'b0, a, b);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    set_port(p, 1'b0, 8'h00, 8'h00);
  endtask

  // Behavioural multiplier core: finish pulse 0..5 cycles into RUN
  initial begin : core_model
    int cnt;
    logic [7:0] cw, cy;
    logic ld, rs;
    cnt = 0; cw = '0; cy = '0;
    forever begin
      @(posedge clk);
      ld = mul_load;
      rs = rst;
      if (ld) begin
        cw = mul_w;
        cy = mul_y;
      end
      #1;
      mul_finish = 1'b0;
      mul_z = 16'($urandom);
      if (rs) begin
        cnt = 0;
      end else if (ld) begin
        cnt = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 5);
        if (cnt == 0 && !stall) begin
          mul_finish = 1'b1;
          mul_z = ref_prod(cw, cy);
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !stall) begin
          mul_finish = 1'b1;
          mul_z = ref_prod(cw, cy);
        end
      end
    end
  end

  // Monitor: arbitration model, timing rules and scoreboard pops
  initial begin : monitor
    logic p_rst, p_busy, p_req0, p_req1, p_fin;
    logic [7:0] p_w0, p_y0, p_w1, p_y1, cur_w, cur_y;
    logic m_last, inflight, cur_port, exp_port;
    logic [15:0] mz0, mz1;
    logic [16:0] e;
    p_rst = 1'b0; p_busy = 1'b0; p_req0 = 1'b0; p_req1 = 1'b0; p_fin = 1'b0;
    p_w0 = '0; p_y0 = '0; p_w1 = '0; p_y1 = '0; cur_w = '0; cur_y = '0;
    m_last = 1'b1; inflight = 1'b0; cur_port = 1'b0; exp_port = 1'b0;
    mz0 = '0; mz1 = '0; e = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q0.delete();
        q1.delete();
        m_last = 1'b1;
        inflight = 1'b0;
        mz0 = '0;
        mz1 = '0;
      end else begin
        if (p_rst) begin
          chk("rst_ack_err", {28'd0, ack1, ack0, err1, err0}, 32'd0);
          chk("rst_z0", {16'd0, z0}, 32'd0);
          chk("rst_z1", {16'd0, z1}, 32'd0);
          chk("rst_load", {31'd0, mul_load}, 32'd0);
          chk("rst_operands", {16'd0, mul_w, mul_y}, 32'd0);
          chk("rst_busy_gid", {30'd0, busy, grant_id}, 32'd0);
        end
        chk("load_timing", {31'd0, mul_load}, {31'd0, !p_busy && (p_req0 || p_req1) && !p_rst});
        if (mul_load) begin
          load_count++;
          exp_port = (p_req0 && p_req1) ? ~m_last : p_req1;
          chk("grant_id", {31'd0, grant_id}, {31'd0, exp_port});
          chk("mul_w", {24'd0, mul_w}, {24'd0, exp_port ? p_w1 : p_w0});
          chk("mul_y", {24'd0, mul_y}, {24'd0, exp_port ? p_y1 : p_y0});
          inflight = 1'b1;
          cur_port = exp_port;
          cur_w = exp_port ? p_w1 : p_w0;
          cur_y = exp_port ? p_y1 : p_y0;
        end else if (inflight) begin
          chk("operands_stable", {16'd0, mul_w, mul_y}, {16'd0, cur_w, cur_y});
        end
        chk("busy", {31'd0, busy}, {31'd0, inflight});
        if (!stall) chk("ack_timing", {31'd0, ack0 | ack1}, {31'd0, p_fin});
        if (ack0 || ack1) begin
          chk("ack_port", {30'd0, ack1, ack0}, cur_port ? 32'd2 : 32'd1);
          if (ack0) begin
            if (q0.size() == 0) begin
              checks++; failures++;
              $display("FAIL ack0_unexpected: got ack0 expected no pending job at %0t", $time);
            end else begin
              e = q0.pop_front();
              chk("z0", {16'd0, z0}, {16'd0, e[15:0]});
              chk("err0", {31'd0, err0}, {31'd0, e[16]});
              mz0 = e[15:0];
            end
          end
          if (ack1) begin
            if (q1.size() == 0) begin
              checks++; failures++;
              $display("FAIL ack1_unexpected: got ack1 expected no pending job at %0t", $time);
            end else begin
              e = q1.pop_front();
              chk("z1", {16'd0, z1}, {16'd0, e[15:0]});
              chk("err1", {31'd0, err1}, {31'd0, e[16]});
              mz1 = e[15:0];
            end
          end
          m_last = ack1;
          inflight = 1'b0;
        end
        if (!ack0) chk("z0_hold", {16'd0, z0}, {16'd0, mz0});
        if (!ack1) chk("z1_hold", {16'd0, z1}, {16'd0, mz1});
      end
      p_rst = rst; p_busy = busy; p_fin = mul_finish;
      p_req0 = req0; p_req1 = req1;
      p_w0 = w0; p_y0 = y0; p_w1 = w1; p_y1 = y1;
    end
  end

  initial begin : guard
    #400000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int lc;
    int cyc;
    int acks;
    bit ok;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single job on port 0
    lc = load_count;
    one_job(0, 8'h85, 8'h03, {1'b0, 16'h800F}, 1'b0);
    chk("t1_load_pulses", 32'(load_count - lc), 32'd1);

    // simultaneous requests after reset: port 0 first
    apply_reset();
    fork
      one_job(0, 8'h02, 8'h03, {1'b0, 16'h0006}, 1'b0);
      one_job(1, 8'h84, 8'h84, {1'b0, 16'h0010}, 1'b0);
    join

    // both held for four jobs: alternating grants
    fork
      drive_jobs(0, 2, 1);
      drive_jobs(1, 2, 1);
    join

    // reset during RUN cycle 3 of a port-1 job, then re-request
    fixed_lat = 12;
    set_port(1, 1'b1, 8'h83, 8'h06);
    push_exp(1, {1'b0, 16'h8012});
    wait_grant(1, ok);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    set_port(1, 1'b0, 8'h83, 8'h06);
    @(posedge clk); #1 rst = 1'b0;
    fixed_lat = -1;
    one_job(1, 8'h83, 8'h06, {1'b0, 16'h8012}, 1'b0);

    // operand change after grant must not reach the core
    one_job(0, 8'h05, 8'h03, {1'b0, 16'h000F}, 1'b1);
    // negative zero passes through
    one_job(1, 8'h80, 8'h05, {1'b0, 16'h8000}, 1'b0);

    // stalled core
    stall = 1'b1;
    set_port(0, 1'b1, 8'h11, 8'h22);
`ifdef MULT_ARB_TIMEOUT_EN
    push_exp(0, {1'b1, 16'h0000});
    wait_grant(0, ok);
    wait_ack(0, cyc);
    chk("timeout_latency", 32'(cyc), 32'd32);
    @(posedge clk); #1;
    set_port(0, 1'b0, 8'h00, 8'h00);
    stall = 1'b0;
`else
    wait_grant(0, ok);
    acks = 0;
    repeat (60) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    chk("stall_no_ack", 32'(acks), 32'd0);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    set_port(0, 1'b0, 8'h00, 8'h00);
    apply_reset();
    stall = 1'b0;
`endif

    // randomized traffic on both ports
    fork
      drive_jobs(0, 15, 0);
      drive_jobs(1, 15, 0);
    join
    repeat (4) @(posedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
